// File: rtl/washing_machine_ctrl.sv
// Washing machine sequencer: soak, wash, drain, N rinse/drain passes, spin.
// Per-phase timers are internal; stop always routes through a drain before idling.
module washing_machine_ctrl #(
  parameter int CNT_W         = 16,
  parameter int SOAK_LOW_CYC  = 20,
  parameter int SOAK_HIGH_CYC = 40,
  parameter int WASH_LOW_CYC  = 30,
  parameter int WASH_HIGH_CYC = 60,
  parameter int RINSE_CYC     = 25,
  parameter int DRAIN_CYC     = 10,
  parameter int SPIN_CYC      = 35,
  parameter int N_RINSE       = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             select,
  input  logic             stop,
  input  logic             pause,
  input  logic             door_closed,
  output logic             idle,
  output logic             soak_low,
  output logic             soak_high,
  output logic             wash_low,
  output logic             wash_high,
  output logic             rinse,
  output logic             spin,
  output logic             drain,
  output logic             door_lock,
  output logic             done,
  output logic [2:0]       rinse_cnt,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SOAK  = 3'd1,
    S_WASH  = 3'd2,
    S_DRAIN = 3'd3,
    S_RINSE = 3'd4,
    S_SPIN  = 3'd5
  } state_t;

  localparam logic [2:0] RINSE_MAX = 3'(N_RINSE);

  state_t           state, state_nxt;
  logic             mode, mode_nxt;
  logic             abort, abort_nxt;
  logic [2:0]       rcnt, rcnt_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic             done_nxt;
  logic             run, expire;

  // Load value for a phase: duration minus one, so a phase spans exactly
  // its duration in run cycles.
  function automatic logic [CNT_W-1:0] phase_len(input state_t st, input logic m);
    case (st)
      S_SOAK:  return m ? CNT_W'(SOAK_HIGH_CYC - 1) : CNT_W'(SOAK_LOW_CYC - 1);
      S_WASH:  return m ? CNT_W'(WASH_HIGH_CYC - 1) : CNT_W'(WASH_LOW_CYC - 1);
      S_DRAIN: return CNT_W'(DRAIN_CYC - 1);
      S_RINSE: return CNT_W'(RINSE_CYC - 1);
      S_SPIN:  return CNT_W'(SPIN_CYC - 1);
      default: return '0;
    endcase
  endfunction

  assign run    = !pause && door_closed;
  assign expire = run && (timer == '0);

  always_comb begin
    state_nxt = state;
    mode_nxt  = mode;
    abort_nxt = abort;
    rcnt_nxt  = rcnt;
    timer_nxt = timer;
    done_nxt  = 1'b0;

    if (state == S_IDLE) begin
      timer_nxt = '0;
      if (start && door_closed && !stop) begin
        state_nxt = S_SOAK;
        mode_nxt  = select;
        rcnt_nxt  = '0;
        abort_nxt = 1'b0;
        timer_nxt = phase_len(S_SOAK, select);
      end
    end else begin
      if (stop) abort_nxt = 1'b1;

      if (stop && state != S_DRAIN) begin
        // Abort from any wet/spinning phase: drain fully before releasing.
        state_nxt = S_DRAIN;
        timer_nxt = phase_len(S_DRAIN, mode);
      end else if (expire) begin
        case (state)
          S_SOAK: begin
            state_nxt = S_WASH;
            timer_nxt = phase_len(S_WASH, mode);
          end
          S_WASH: begin
            state_nxt = S_DRAIN;
            timer_nxt = phase_len(S_DRAIN, mode);
          end
          S_DRAIN: begin
            if (abort || stop) begin
              state_nxt = S_IDLE;
              abort_nxt = 1'b0;
              rcnt_nxt  = '0;
              timer_nxt = '0;
            end else if (rcnt < RINSE_MAX) begin
              state_nxt = S_RINSE;
              timer_nxt = phase_len(S_RINSE, mode);
            end else begin
              state_nxt = S_SPIN;
              timer_nxt = phase_len(S_SPIN, mode);
            end
          end
          S_RINSE: begin
            state_nxt = S_DRAIN;
            timer_nxt = phase_len(S_DRAIN, mode);
            if (rcnt < RINSE_MAX) rcnt_nxt = rcnt + 3'd1;
          end
          S_SPIN: begin
            state_nxt = S_IDLE;
            timer_nxt = '0;
            done_nxt  = 1'b1;
          end
          default: begin
            state_nxt = S_IDLE;
            timer_nxt = '0;
          end
        endcase
      end else if (run) begin
        timer_nxt = timer - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      mode  <= 1'b0;
      abort <= 1'b0;
      rcnt  <= '0;
      timer <= '0;
    end else begin
      state <= state_nxt;
      mode  <= mode_nxt;
      abort <= abort_nxt;
      rcnt  <= rcnt_nxt;
      timer <= timer_nxt;
    end
  end

  // Phase outputs are decoded from the next state and registered, so they
  // line up with the state register and never glitch into the drivers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle      <= 1'b1;
      soak_low  <= 1'b0;
      soak_high <= 1'b0;
      wash_low  <= 1'b0;
      wash_high <= 1'b0;
      rinse     <= 1'b0;
      spin      <= 1'b0;
      drain     <= 1'b0;
      door_lock <= 1'b0;
      done      <= 1'b0;
    end else begin
      idle      <= (state_nxt == S_IDLE);
      soak_low  <= (state_nxt == S_SOAK) && !mode_nxt;
      soak_high <= (state_nxt == S_SOAK) &&  mode_nxt;
      wash_low  <= (state_nxt == S_WASH) && !mode_nxt;
      wash_high <= (state_nxt == S_WASH) &&  mode_nxt;
      rinse     <= (state_nxt == S_RINSE);
      spin      <= (state_nxt == S_SPIN);
      drain     <= (state_nxt == S_DRAIN);
      door_lock <= (state_nxt != S_IDLE);
      done      <= done_nxt;
    end
  end

  assign rinse_cnt = rcnt;
  assign remaining = timer;

endmodule

// File: tb/tb_washing_machine_ctrl.sv
// Directed bench for washing_machine_ctrl: a table of full-cycle vectors plus
// hand-written pause, door, stop and asynchronous-reset sequences.
module tb_washing_machine_ctrl;

  localparam logic [7:0] P_IDLE = 8'b1000_0000;
  localparam logic [7:0] P_SL   = 8'b0100_0000;
  localparam logic [7:0] P_SH   = 8'b0010_0000;
  localparam logic [7:0] P_WL   = 8'b0001_0000;
  localparam logic [7:0] P_WH   = 8'b0000_1000;
  localparam logic [7:0] P_RI   = 8'b0000_0100;
  localparam logic [7:0] P_SP   = 8'b0000_0010;
  localparam logic [7:0] P_DR   = 8'b0000_0001;

  logic        clk, rst;
  logic        start, select, stop, pause, door_closed;
  logic        idle, soak_low, soak_high, wash_low, wash_high, rinse, spin, drain;
  logic        door_lock, done;
  logic [2:0]  rinse_cnt;
  logic [15:0] remaining;

  int checks = 0;
  int passed = 0;
  int done_count = 0;
  int onehot_err = 0;

  washing_machine_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .select(select), .stop(stop),
    .pause(pause), .door_closed(door_closed),
    .idle(idle), .soak_low(soak_low), .soak_high(soak_high),
    .wash_low(wash_low), .wash_high(wash_high), .rinse(rinse), .spin(spin),
    .drain(drain), .door_lock(door_lock), .done(done),
    .rinse_cnt(rinse_cnt), .remaining(remaining)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (rst) begin
      if (done) done_count++;
      if ($countones({idle, soak_low, soak_high, wash_low, wash_high, rinse, spin, drain}) != 1)
        onehot_err++;
    end
  end

  typedef struct {
    logic        start, select, stop, pause, door;
    int          n;
    logic [7:0]  ph;
    logic [15:0] rem;
    logic [2:0]  rc;
    logic        lock, dn;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic st, input logic sel, input logic sp,
                              input logic pz, input logic dr, input int n,
                              input logic [7:0] ph, input logic [15:0] rem,
                              input logic [2:0] rc, input logic lock, input logic dn);
    vec_t v;
    v.start = st; v.select = sel; v.stop = sp; v.pause = pz; v.door = dr; v.n = n;
    v.ph = ph; v.rem = rem; v.rc = rc; v.lock = lock; v.dn = dn;
    return v;
  endfunction

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic sel, input logic sp,
                       input logic pz, input logic dr);
    start = st; select = sel; stop = sp; pause = pz; door_closed = dr;
  endtask

  // scoreboard compare: phase vector, remaining, rinse_cnt, door_lock, done
  task automatic check(input string name, input logic [7:0] ph, input logic [15:0] rem,
                       input logic [2:0] rc, input logic lock, input logic dn);
    logic [28:0] got, exp;
    got = {idle, soak_low, soak_high, wash_low, wash_high, rinse, spin, drain,
           remaining, rinse_cnt, door_lock, done};
    exp = {ph, rem, rc, lock, dn};
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got ph=%b rem=%0d rc=%0d lock=%b done=%b, expected ph=%b rem=%0d rc=%0d lock=%b done=%b",
                  name, got[28:21], got[20:5], got[4:2], got[1], got[0],
                  ph, rem, rc, lock, dn);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 1);

    // full low-mode cycle, then IDLE corner cases
    vecs[0]  = mk(1, 0, 0, 0, 1,  1, P_SL,   19, 0, 1, 0);
    vecs[1]  = mk(0, 0, 0, 0, 1, 19, P_SL,    0, 0, 1, 0);
    vecs[2]  = mk(0, 0, 0, 0, 1,  1, P_WL,   29, 0, 1, 0);
    vecs[3]  = mk(0, 0, 0, 0, 1, 29, P_WL,    0, 0, 1, 0);
    vecs[4]  = mk(0, 0, 0, 0, 1,  1, P_DR,    9, 0, 1, 0);
    vecs[5]  = mk(0, 0, 0, 0, 1, 10, P_RI,   24, 0, 1, 0);
    vecs[6]  = mk(0, 0, 0, 0, 1, 25, P_DR,    9, 1, 1, 0);
    vecs[7]  = mk(0, 0, 0, 0, 1, 10, P_RI,   24, 1, 1, 0);
    vecs[8]  = mk(0, 0, 0, 0, 1, 25, P_DR,    9, 2, 1, 0);
    vecs[9]  = mk(0, 0, 0, 0, 1, 10, P_SP,   34, 2, 1, 0);
    vecs[10] = mk(0, 0, 0, 0, 1, 34, P_SP,    0, 2, 1, 0);
    vecs[11] = mk(0, 0, 0, 0, 1,  1, P_IDLE,  0, 2, 0, 1);
    vecs[12] = mk(0, 0, 0, 0, 1,  1, P_IDLE,  0, 2, 0, 0);
    vecs[13] = mk(1, 0, 0, 0, 0,  3, P_IDLE,  0, 2, 0, 0);
    vecs[14] = mk(1, 0, 1, 0, 1,  2, P_IDLE,  0, 2, 0, 0);

    #12 rst = 1'b1;
    @(posedge clk); #1;
    check("reset", P_IDLE, 0, 0, 0, 0);

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].start, vecs[i].select, vecs[i].stop, vecs[i].pause, vecs[i].door);
      tick(vecs[i].n);
      check($sformatf("vec%0d", i), vecs[i].ph, vecs[i].rem, vecs[i].rc, vecs[i].lock, vecs[i].dn);
    end
    check_int("done_pulses_low", done_count, 1);

    // high mode, select toggled mid-cycle, pause in WASH, stop during DRAIN
    drive(1, 1, 0, 0, 1); tick(1);
    check("high_soak", P_SH, 39, 0, 1, 0);
    drive(0, 0, 0, 0, 1); tick(39);
    check("high_soak_end", P_SH, 0, 0, 1, 0);
    tick(1);
    check("high_wash", P_WH, 59, 0, 1, 0);
    select = 1'b1; tick(47); select = 1'b0;
    check("high_wash_12", P_WH, 12, 0, 1, 0);
    pause = 1'b1; tick(15);
    check("pause_hold", P_WH, 12, 0, 1, 0);
    pause = 1'b0; tick(12);
    check("pause_resume", P_WH, 0, 0, 1, 0);
    tick(1);
    check("pause_exit", P_DR, 9, 0, 1, 0);
    stop = 1'b1; tick(1); stop = 1'b0;
    check("stop_in_drain", P_DR, 8, 0, 1, 0);
    tick(8);
    check("stop_drain_end", P_DR, 0, 0, 1, 0);
    tick(1);
    check("stop_drain_idle", P_IDLE, 0, 0, 0, 0);

    // low mode, door open in WASH, stop during second RINSE
    done_count = 0;
    drive(1, 0, 0, 0, 1); tick(1); start = 1'b0;
    tick(20);
    check("low2_wash", P_WL, 29, 0, 1, 0);
    tick(17);
    door_closed = 1'b0; tick(15);
    check("door_hold", P_WL, 12, 0, 1, 0);
    door_closed = 1'b1; tick(13);
    check("door_exit", P_DR, 9, 0, 1, 0);
    tick(10 + 25 + 10 + 5);
    check("rinse2_mid", P_RI, 19, 1, 1, 0);
    stop = 1'b1; tick(1); stop = 1'b0;
    check("stop_rinse", P_DR, 9, 1, 1, 0);
    tick(9);
    check("abort_drain_end", P_DR, 0, 1, 1, 0);
    tick(1);
    check("abort_idle", P_IDLE, 0, 0, 0, 0);
    check_int("done_pulses_abort", done_count, 0);

    // asynchronous reset in the middle of SPIN
    drive(1, 0, 0, 0, 1); tick(1); start = 1'b0;
    tick(130 + 5);
    check("spin_mid", P_SP, 29, 2, 1, 0);
    #3 rst = 1'b0;
    #1;
    check("async_reset", P_IDLE, 0, 0, 0, 0);
    @(negedge clk); rst = 1'b1;
    tick(2);
    check("after_reset", P_IDLE, 0, 0, 0, 0);

    check_int("onehot", onehot_err, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
